rr_enum_arbiter: RTL



---
 rtl/rr_enum_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rr_enum_arbiter.sv
// Round-robin arbiter granting one of N requesters a single-owner resource.
// Each grant runs GRANT (1 cycle) -> HOLD (bounded) -> RECOVER (1 cycle) -> IDLE.
module rr_enum_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 release_i,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid,
  output logic [1:0]           state,
  output logic                 timeout
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned CW  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_gnt;
  logic [IDW-1:0]   r_gnt_id;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [CW-1:0]    r_hold_cnt;
  logic [IDW-1:0]   r_last;

  state_t           w_state_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic [IDW-1:0]   w_gnt_id_nxt;
  logic             w_gnt_valid_nxt;
  logic             w_timeout_nxt;
  logic [CW-1:0]    w_hold_cnt_nxt;
  logic [IDW-1:0]   w_last_nxt;

  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic             w_vol_exit;
  logic             w_expired;

  // First active requester scanning upward from the slot after the last owner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!w_found && req[IDW'((32'(r_last) + i) % N)]) begin
        w_found = 1'b1;
        w_pick  = IDW'((32'(r_last) + i) % N);
      end
    end
  end

  // Voluntary release or a dropped request outranks expiry.
  assign w_vol_exit = release_i | ~req[r_gnt_id];
  assign w_expired  = (r_hold_cnt == CW'(MAX_HOLD));

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_last_nxt      = r_last;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt         = GRANT;
          w_gnt_nxt           = '0;
          w_gnt_nxt[w_pick]   = 1'b1;
          w_gnt_id_nxt        = w_pick;
          w_gnt_valid_nxt     = 1'b1;
        end
      end
      GRANT: begin
        w_state_nxt    = HOLD;
        w_hold_cnt_nxt = CW'(1);
      end
      HOLD: begin
        if (w_vol_exit || w_expired) begin
          w_state_nxt     = RECOVER;
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_last_nxt      = r_gnt_id;
          w_timeout_nxt   = w_expired & ~w_vol_exit;
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt + CW'(1);
        end
      end
      RECOVER: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
      r_last      <= IDW'(N - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign state     = r_state;
  assign timeout   = r_timeout;

endmodule
